// File: rtl/adder_pipe.sv
// Pipelined adder: operands captured into stage 1, sum/carry computed into a
// small in-order result FIFO, with a credit-based in_ready and a pop counter.
module adder_pipe #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  // Handshake rule for both ports: a beat transfers on a rising edge where
  // valid && ready; the producer holds payload and valid until that edge.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CNT_W-1:0] txn_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Stage-1 operand register
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;

  // Result FIFO
  logic [WIDTH-1:0] r_fifo_sum  [FIFO_DEPTH];
  logic             r_fifo_cout [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [CNT_W-1:0] r_txn_count;
  logic             r_in_reset;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH:0]   w_result;
  logic [CW:0]      w_occupancy;
  logic [CW:0]      w_depth;
  logic             w_out_valid;

  // Credits count both FIFO entries and the stage-1 entry, so the stage-1
  // write into the FIFO can never find it full.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_s1_valid};
  assign w_depth     = (CW+1)'(FIFO_DEPTH);
  assign in_ready    = !r_in_reset && (w_occupancy < w_depth);

  assign w_out_valid = (r_count != '0);
  assign w_accept    = in_valid && in_ready;
  assign w_push      = r_s1_valid;
  assign w_pop       = w_out_valid && out_ready;

  assign w_result = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, r_s1_cin};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_reset <= 1'b1;
    end else begin
      r_in_reset <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a   <= a;
      r_s1_b   <= b;
      r_s1_cin <= cin;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifo_sum[r_wr_ptr]  <= w_result[WIDTH-1:0];
      r_fifo_cout[r_wr_ptr] <= w_result[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_txn_count <= '0;
    end else if (w_pop) begin
      r_txn_count <= r_txn_count + CNT_W'(1);
    end
  end

  assign out_valid = w_out_valid;
  assign sum       = w_out_valid ? r_fifo_sum[r_rd_ptr]  : '0;
  assign cout      = w_out_valid ? r_fifo_cout[r_rd_ptr] : 1'b0;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed steps plus a long random run, checked every
// cycle against an in-order queue of expected results.
module tb_adder_pipe;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] txn_count;

  logic             dir_ready;
  logic             rand_ready;
  logic             rand_mode;

  int               n_cmp;
  int               n_fail;
  int               cyc;

  // Reference model: every accepted beat, oldest first, with its accept edge.
  logic [WIDTH:0]   exp_q[$];
  int               acc_q[$];
  int               model_cnt;
  logic             prev_rst;
  logic             started;

  assign out_ready = rand_mode ? rand_ready : dir_ready;

  adder_pipe #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .txn_count (txn_count)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rand_ready = ($urandom_range(15, 0) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard: check outputs against the model, then advance the model by
  // what the upcoming edge will do.
  always @(negedge clk) begin
    logic           vis;
    logic [WIDTH:0] head;
    int             s;
    if (started) begin
      vis  = (exp_q.size() > 0) && (acc_q[0] < cyc);
      head = vis ? exp_q[0] : '0;
      chk("in_ready", 32'(in_ready), prev_rst ? 32'd0 : 32'(exp_q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(vis));
      chk("sum", 32'(sum), 32'(head[WIDTH-1:0]));
      chk("cout", 32'(cout), 32'(head[WIDTH]));
      chk("txn_count", 32'(txn_count), 32'(model_cnt));
    end
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      model_cnt = 0;
      prev_rst  = 1'b1;
      started   = 1'b1;
    end else if (started) begin
      prev_rst = 1'b0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        model_cnt = (model_cnt + 1) % 65536;
      end
      if (in_valid && in_ready) begin
        s = int'(a) + int'(b) + int'(cin);
        exp_q.push_back(s[WIDTH:0]);
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic ic, output int waited);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && k < 300) begin
      k++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int w;
    int n_acc;
    logic got;
    logic [8:0] v;
    n_cmp = 0; n_fail = 0; model_cnt = 0;
    prev_rst = 1'b0; started = 1'b0;
    rand_mode = 1'b0; dir_ready = 1'b0;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 7 + 9: result one edge after accept, counted after its pop
    dir_ready = 1'b1;
    send(4'h7, 4'h9, 1'b0, w);
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("7+9_sum", 32'(sum), 32'h0);
    chk("7+9_cout", 32'(cout), 32'd1);
    @(negedge clk);
    chk("first_count", 32'(txn_count), 32'd1);
    drain();

    send(4'hF, 4'hF, 1'b1, w);
    @(negedge clk); @(negedge clk);
    chk("max_sum", 32'(sum), 32'hF);
    chk("max_cout", 32'(cout), 32'd1);
    drain();
    send(4'h0, 4'h0, 1'b0, w);
    @(negedge clk); @(negedge clk);
    chk("zero_valid", 32'(out_valid), 32'd1);
    chk("zero_sum", 32'(sum), 32'h0);
    chk("zero_cout", 32'(cout), 32'd0);
    drain();

    // Exhaustive operand sweep at full rate
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      send(v[3:0], v[7:4], v[8], w);
    end
    drain();

    // Backpressure: six offered, four accepted
    dir_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = 4'(i); b = 4'h1; cin = 1'b0; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 3 && !got; k++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        @(posedge clk);
        #1;
      end
      if (got) n_acc++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(n_acc), 32'd4);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    @(negedge clk);
    chk("bp_head0", 32'(sum), 32'd1);
    @(negedge clk);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_head1", 32'(sum), 32'd2);
    drain();

    // Full-rate stream
    pulse_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      send(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), w);
      chk("stream_no_stall", 32'(w), 32'd0);
    end
    drain();
    chk("stream_count", 32'(txn_count), 32'd16);

    // Reset with results pending
    dir_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(i + 8), 4'h3, 1'b1, w);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(txn_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    send(4'h2, 4'h3, 1'b0, w);
    @(negedge clk); @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sum", 32'(sum), 32'd5);
    chk("post_rst_cout", 32'(cout), 32'd0);
    drain();

    // Random traffic long enough to wrap txn_count
    pulse_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if ($urandom_range(31, 0) == 0) begin
        @(posedge clk);
        #1;
      end
      send(4'($urandom), 4'($urandom), 1'($urandom), w);
    end
    drain();
    chk("wrap_count", 32'(txn_count), 32'd4464);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Pipelined 4-bit adder DUT: the responder end of the adder stimulus interface.
- Accepts operand transactions from the bench driver over a valid/ready handshake and computes sum/carry through a registered stage.
- Returns results in order over a second valid/ready handshake, through an output FIFO that absorbs monitor/scoreboard backpressure.
- Keeps a running count of completed result transactions.

Parameters:
- WIDTH, 4, operand and sum width in bits.
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of txn_count.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept an operand transaction.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  FIFO head result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  FIFO head sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  FIFO head carry out, bit WIDTH of a+b+cin.
- txn_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset is synchronous. While reset is high at a clock edge:
  - stage-1 valid, FIFO pointers, count and txn_count clear.
  - Outputs after that edge: in_ready=0 while reset is held, out_valid=0, sum=0, cout=0, txn_count=0.
  - Operand or result data in flight is discarded; no output handshake completes in a reset cycle.
  - in_ready rises the first cycle after reset deasserts.
- Accept: occurs on an edge where in_valid && in_ready. a, b and cin are captured into the stage-1 register and s1_valid is set.
- Compute: on the next edge, {cout,sum} = a + b + cin is computed at WIDTH+1 bits and the entry is written to the FIFO tail. Stage 1 then holds the next accept, if any; otherwise s1_valid clears.
- Latency: accept at edge N, result visible at the FIFO head (out_valid=1) after edge N+1 when the FIFO was empty. Full-rate throughput is 1 transaction per cycle.
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH.
  - Computed from registered state only; no combinational path from out_ready or in_valid.
  - This credit rule guarantees stage 1 never writes into a full FIFO.
- Output:
  - out_valid = (fifo_count != 0).
  - sum and cout present the head entry and hold stable while out_valid && !out_ready.
  - When out_valid=0, sum and cout are 0.
  - A pop occurs on an edge where out_valid && out_ready.
- Simultaneous push and pop on the same edge: fifo_count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Ordering: results leave strictly in accept order.
- txn_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- in_valid without in_ready: no capture. The driver must hold a, b, cin and in_valid; the block does not check this.
- X or unknown data is not allowed on an accepted beat.
- There are no other states. The control "FSM" is implicit in the s1_valid and fifo_count state:
  - EMPTY: count=0, s1=0.
  - FILLING: 0<count+s1<DEPTH.
  - FULL: count+s1=DEPTH, in_ready=0.

Test Plan:
- Reset then a=4'h7, b=4'h9, cin=0, out_ready=1 -> accept at edge N; out_valid=1 after N+1 with sum=4'h0, cout=1; txn_count=1 after the pop edge.
- a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1. a=0, b=0, cin=0 -> sum=0, cout=0. Sweep all 512 a/b/cin combinations against the scoreboard model; zero mismatches.
- out_ready=0, present 6 back-to-back transactions (a=i, b=1) -> exactly 4 accepted, in_ready=0 once count+s1=4. Raise out_ready -> sums 1,2,3,4 in order; in_ready reasserts the cycle after the first pop.
- out_ready=1 constantly, 16 back-to-back transactions -> in_ready never drops, one result per cycle after the initial 2-cycle latency, txn_count=16.
- Fill with 3 results pending, assert reset for 1 cycle -> out_valid=0, txn_count=0, old results never appear; a new transaction 2+3 returns sum=5, cout=0.
- Random in_valid/out_ready toggling, 70000 transactions -> txn_count wraps to 70000-65536=4464, ordering and values match the scoreboard.
